// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// One-bit full-adder cell.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  // Combinational sum and carry of three input bits.
  always_comb begin
    sum   = a ^ b ^ cin;
    carry = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus a carry-in,
// LSB first, one bit per clock through a single full-adder cell.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int unsigned    CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;

  fulladder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Result register after shifting in the current sum bit at the MSB end.
  always_comb begin
    res_next = {fa_sum, {(WIDTH-1){1'b0}}} | (res_sr >> 1);
  end

  // Controller FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            res_sr <= '0;
            carry  <= cin_in;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          // abort outranks both a stray start and the final bit edge
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            carry  <= fa_carry;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST) begin
              sum_out <= res_next;
              cout    <= fa_carry;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            res_sr <= '0;
            carry  <= cin_in;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table plus
// hand-written abort, reset, ignored-start and back-to-back sequences.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin_in  (cin_in),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[7];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0");
      end else begin
        mon_e = sb.pop_front();
        chk("sum_out", 32'(sum_out), 32'(mon_e.s));
        chk("cout", 32'(cout), 32'(mon_e.c));
      end
    end
  end

  // Drive one start request; E0 is the next rising edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] es, input logic ec, input bit push);
    exp_t e;
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    if (push) begin
      e.s = es; e.c = ec;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  // Wait for done at falling edges; returns latency from E0 and busy-cycle count.
  task automatic wait_done(input int limit, output int lat, output int bcnt);
    lat = -1;
    bcnt = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - start_cyc;
        break;
      end
      if (busy) bcnt++;
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done", limit);
    end
  endtask

  initial begin
    int lat, bc, n0, d1, d2;
    logic [W-1:0] prev_s;
    logic prev_c;

    vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, c: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1};
    vecs[2] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, s: 8'h00, c: 1'b1};
    vecs[3] = '{a: 8'h3C, b: 8'h42, cin: 1'b0, s: 8'h7E, c: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, c: 1'b1};
    vecs[5] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, s: 8'h80, c: 1'b0};
    vecs[6] = '{a: 8'h55, b: 8'hAA, cin: 1'b0, s: 8'hFF, c: 1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    a_in = '0; b_in = '0; cin_in = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum_out), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    // First start on the first edge with rst_n high; zero operands.
    rst_n = 1'b1;
    issue(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
    wait_done(20, lat, bc);
    chk("first_latency", 32'(lat), 32'd8);
    chk("first_busy_cycles", 32'(bc), 32'd8);
    @(negedge clk);
    chk("first_done_width", 32'(done), 32'd0);
    chk("first_busy_after", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, 1'b1);
      wait_done(20, lat, bc);
      chk("vec_latency", 32'(lat), 32'd8);
      chk("vec_busy_cycles", 32'(bc), 32'd8);
      @(negedge clk);
      chk("vec_done_width", 32'(done), 32'd0);
    end

    // Start pulsed during RUN cycle 3 must be ignored.
    issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    a_in = 8'hFF; b_in = 8'hFF; cin_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(20, lat, bc);
    chk("ignored_start_latency", 32'(lat), 32'd8);
    @(negedge clk);
    prev_s = 8'h30;
    prev_c = 1'b0;

    // Abort at RUN cycle 4: back to IDLE, no done, outputs unchanged.
    issue(8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
    n0 = done_count;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum_hold", 32'(sum_out), 32'(prev_s));
    chk("abort_cout_hold", 32'(cout), 32'(prev_c));
    repeat (12) @(negedge clk);
    chk("abort_no_done", 32'(done_count), 32'(n0));

    // Reset at RUN cycle 5 clears outputs immediately; no done afterwards.
    issue(8'h33, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum_out), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n0 = done_count;
    repeat (15) @(negedge clk);
    chk("midrst_no_done", 32'(done_count), 32'(n0));
    chk("midrst_idle", 32'(busy), 32'd0);

    // Start held through DONE: back-to-back operations.
    a_in = 8'h3C; b_in = 8'h42; cin_in = 1'b0; start = 1'b1;
    sb.push_back('{s: 8'h7E, c: 1'b0});
    @(posedge clk);
    #1;
    start_cyc = cyc;
    wait_done(20, lat, bc);
    d1 = cyc;
    chk("b2b_first_latency", 32'(lat), 32'd8);
    a_in = 8'h80; b_in = 8'h80; cin_in = 1'b0;
    sb.push_back('{s: 8'h00, c: 1'b1});
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    chk("b2b_no_idle", 32'(busy), 32'd1);
    wait_done(20, lat, bc);
    d2 = cyc;
    chk("b2b_done_spacing", 32'(d2 - d1), 32'd9);
    @(negedge clk);
    chk("b2b_done_width", 32'(done), 32'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new addition; sampled on the rising edge.
REQ-005 abort  input  1  cancel an addition in progress; sampled on the rising edge.
REQ-006 a_in  input  WIDTH  operand A; captured when start is accepted.
REQ-007 b_in  input  WIDTH  operand B; captured when start is accepted.
REQ-008 cin_in  input  1  carry-in; captured when start is accepted.
REQ-009 busy  output  1  high while state is RUN.
REQ-010 done  output  1  one-cycle pulse; result is valid.
REQ-011 sum_out  output  WIDTH  result of A+B+cin, modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.

Function
REQ-013 The block SHALL compute the sum bit-serially, LSB first, one bit per clock, through a single one-bit full-adder cell and a registered carry.
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 Transitions:
- IDLE -> RUN on start=1.
- RUN -> DONE after WIDTH bit cycles.
- RUN -> IDLE on abort=1.
- DONE -> RUN on start=1.
- DONE -> IDLE otherwise.
REQ-016 On an accepted start edge E0, the block SHALL load the A/B shift registers, load the carry register with cin_in, and clear the bit counter.
REQ-017 Edges E1..EWIDTH SHALL each process one bit (E1 = bit 0), shifting the sum bit into a result shift register and registering the carry.
REQ-018 Bit counter: width clog2(WIDTH)+1; the RUN -> DONE transition SHALL occur on edge EWIDTH (counter = WIDTH-1).
REQ-019 done SHALL be 1 for exactly the one cycle following EWIDTH (state DONE), giving a start-to-done latency of WIDTH cycles.
REQ-020 sum_out and cout SHALL update only on the transition into DONE and SHALL hold until the next transition into DONE or reset; partial results SHALL never appear on them.
REQ-021 start while in RUN SHALL be ignored, with no effect on operands, counter or carry.
REQ-022 start in DONE SHALL be accepted on the same edge that leaves DONE, giving back-to-back operations with no idle cycle.
REQ-023 abort in RUN SHALL return to IDLE on that edge, with no done pulse and sum_out/cout unchanged.
REQ-024 abort in IDLE or DONE SHALL be ignored.
REQ-025 If start and abort are both high in RUN, abort SHALL win.
REQ-026 Operand inputs SHALL be don't-care except on the accepted start edge.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, busy=0, done=0, sum_out=0, cout=0, counter=0, carry=0 and the shift registers to 0.
REQ-028 Reset asserted mid-RUN SHALL discard the operation; after release, the block SHALL wait for a new start.
REQ-029 The first start SHALL be accepted on the first rising edge at which rst_n is high.

Structure
REQ-030 Package serial_add_pkg SHALL hold the FSM state type (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-031 Exactly one sub-module SHALL be used: the existing fulladder cell (a, b, cin -> sum, carry), instantiated once.
REQ-032 The controller SHALL contain only the FSM, counter, shift and carry registers, and output registers.

Verification (WIDTH=8)
REQ-033 Start with A=0x00, B=0x00, cin=0 -> busy high for 8 cycles; done pulses once, 8 edges after start; sum_out=0x00, cout=0.
REQ-034 Start with A=0xFF, B=0x01, cin=0 -> sum_out=0x00, cout=1; A=0xA5, B=0x5A, cin=1 -> sum_out=0x00, cout=1; A=0x3C, B=0x42, cin=0 -> sum_out=0x7E, cout=0.
REQ-035 Start 0x10+0x20, then pulse start with 0xFF+0xFF at RUN cycle 3 -> second start ignored; result is 0x30, cout=0.
REQ-036 Start 0x01+0x01, then abort at RUN cycle 4 -> IDLE next edge, no done pulse, outputs keep their previous values; rst_n low at RUN cycle 5 of a new operation -> all outputs 0 immediately, no done pulse after release.
REQ-037 Start held high through DONE with new operands 0x80+0x80 -> second operation starts with no idle cycle; done pulses twice, 9 cycles apart; second result sum_out=0x00, cout=1.
